// File: rtl/cpu_sequencer_if.sv
// ---------------------------------------------------------------------------
// cpu_sequencer_if
// Bundles the sequencer's ROM, RAM and ALU-control signals.
//
// Optional feature macro: SEQ_ILLEGAL_TRAP_EN (adds the 'illegal' flag).
//
// Signals:
//   run       in   permits a new instruction fetch
//   instr     in   ROM read data, opcode [7:4], immediate [3:0]
//   rom_addr  out  ROM address
//   rom_rd    out  ROM read strobe
//   ram_addr  out  RAM address (operand register)
//   ram_rd    out  RAM read strobe
//   ram_wr    out  RAM write strobe
//   op        out  ALU opcode
//   imm       out  immediate nibble
//   im_int    out  immediate-add latch pulse
//   din_ld    out  load memory data bus into ALU input register
//   acc_ld    out  load ALU result into accumulator
//   halted    out  sequencer is in HALT
//   illegal   out  illegal opcode trapped (SEQ_ILLEGAL_TRAP_EN only)
//
// Modports: master = the sequencer, slave = the surrounding CPU datapath.
// ---------------------------------------------------------------------------
interface cpu_sequencer_if #(
    parameter int AW = 8
);
    logic          run;
    logic [7:0]    instr;
    logic [AW-1:0] rom_addr;
    logic          rom_rd;
    logic [AW-1:0] ram_addr;
    logic          ram_rd;
    logic          ram_wr;
    logic [3:0]    op;
    logic [3:0]    imm;
    logic          im_int;
    logic          din_ld;
    logic          acc_ld;
    logic          halted;
`ifdef SEQ_ILLEGAL_TRAP_EN
    logic          illegal;

    modport master (
        input  run, instr,
        output rom_addr, rom_rd, ram_addr, ram_rd, ram_wr,
        output op, imm, im_int, din_ld, acc_ld, halted, illegal
    );

    modport slave (
        output run, instr,
        input  rom_addr, rom_rd, ram_addr, ram_rd, ram_wr,
        input  op, imm, im_int, din_ld, acc_ld, halted, illegal
    );
`else
    modport master (
        input  run, instr,
        output rom_addr, rom_rd, ram_addr, ram_rd, ram_wr,
        output op, imm, im_int, din_ld, acc_ld, halted
    );

    modport slave (
        output run, instr,
        input  rom_addr, rom_rd, ram_addr, ram_rd, ram_wr,
        input  op, imm, im_int, din_ld, acc_ld, halted
    );
`endif
endinterface

// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle instruction sequencer / decoder for the 8-bit CPU. Fetches
// instruction bytes from ROM, owns the program counter, instruction register
// and operand-address register, and drives the ALU opcode plus the memory
// and accumulator control strobes.
//
// Optional feature macro: SEQ_ILLEGAL_TRAP_EN
//   defined   : opcodes B..E stop the sequencer in HALT and raise 'illegal'
//   undefined : opcodes B..E execute as a one-byte NOP
//
// Ports:
//   clk   rising-edge system clock
//   rst   asynchronous active-high reset
//   bus   cpu_sequencer_if.master (see the interface file for signals)
//
// Parameters:
//   AW        ROM/RAM address and PC width
//   RESET_PC  PC value loaded on reset
// ---------------------------------------------------------------------------
module cpu_sequencer #(
    parameter int            AW       = 8,
    parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    cpu_sequencer_if.master   bus
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDO = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_STO = 4'h3;
    localparam logic [3:0] OP_PRE = 4'h4;
    localparam logic [3:0] OP_ADD = 4'h5;
    localparam logic [3:0] OP_LDM = 4'h6;
    localparam logic [3:0] OP_ADN = 4'h7;
    localparam logic [3:0] OP_INC = 4'h8;
    localparam logic [3:0] OP_DEC = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_LOAD_IR  = 3'd1,
        ST_DECODE   = 3'd2,
        ST_OP_FETCH = 3'd3,
        ST_OP_LOAD  = 3'd4,
        ST_EXEC     = 3'd5,
        ST_WB       = 3'd6,
        ST_HALT     = 3'd7
    } state_t;

    state_t        state_r;
    logic [AW-1:0] pc_r;
    logic [7:0]    ir_r;
    logic [AW-1:0] areg_r;
`ifdef SEQ_ILLEGAL_TRAP_EN
    logic          illegal_r;
`endif

    logic [3:0]    opc_s;
    logic          op_window_s;
    logic          rom_rd_s;
    logic [AW-1:0] rom_addr_s;
    logic          ram_rd_s;
    logic          ram_wr_s;
    logic          im_int_s;
    logic          din_ld_s;
    logic          acc_ld_s;
    logic [3:0]    op_s;
    logic          halted_s;

    // Instructions whose second byte is an operand address.
    function automatic logic is_two_byte(input logic [3:0] opc);
        logic r;
        case (opc)
            OP_LDO, OP_LDA, OP_STO, OP_PRE, OP_ADD, OP_JMP: r = 1'b1;
            default:                                        r = 1'b0;
        endcase
        return r;
    endfunction

    // Unassigned opcode space B..E.
    function automatic logic is_illegal(input logic [3:0] opc);
        return (opc >= 4'hB) && (opc <= 4'hE);
    endfunction

    // Instructions that write the ALU result back into the accumulator.
    function automatic logic writes_acc(input logic [3:0] opc);
        logic r;
        case (opc)
            OP_LDO, OP_LDA, OP_ADD, OP_ADN, OP_INC, OP_DEC: r = 1'b1;
            default:                                        r = 1'b0;
        endcase
        return r;
    endfunction

    assign opc_s = ir_r[7:4];

    // Sequencer state machine: state, PC, IR and operand register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_FETCH;
            pc_r      <= RESET_PC;
            ir_r      <= 8'h00;
            areg_r    <= {AW{1'b0}};
`ifdef SEQ_ILLEGAL_TRAP_EN
            illegal_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_FETCH: begin
                    // run is only looked at here; an instruction in flight
                    // always completes.
                    if (bus.run) begin
                        state_r <= ST_LOAD_IR;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_LOAD_IR: begin
                    ir_r    <= bus.instr;
                    pc_r    <= pc_r + PC_ONE;
                    state_r <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (is_two_byte(opc_s)) begin
                        state_r <= ST_OP_FETCH;
`ifdef SEQ_ILLEGAL_TRAP_EN
                    end else if (is_illegal(opc_s)) begin
                        illegal_r <= 1'b1;
                        state_r   <= ST_HALT;
`endif
                    end else begin
                        state_r <= ST_EXEC;
                    end
                end
                ST_OP_FETCH: begin
                    state_r <= ST_OP_LOAD;
                end
                ST_OP_LOAD: begin
                    // PC wraps naturally at the top of the address space.
                    areg_r  <= bus.instr[AW-1:0];
                    pc_r    <= pc_r + PC_ONE;
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (opc_s == OP_HLT) begin
                        state_r <= ST_HALT;
                    end else begin
                        state_r <= ST_WB;
                    end
                end
                ST_WB: begin
                    if (opc_s == OP_JMP) begin
                        pc_r <= areg_r;
                    end else begin
                        pc_r <= pc_r;
                    end
                    state_r <= ST_FETCH;
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    state_r <= ST_FETCH;
                end
            endcase
        end
    end

    assign op_window_s = (state_r == ST_DECODE)   || (state_r == ST_OP_FETCH) ||
                         (state_r == ST_OP_LOAD)  || (state_r == ST_EXEC)     ||
                         (state_r == ST_WB);

    // Strobe decode from the registered state; held low throughout reset.
    always_comb begin
        rom_rd_s   = 1'b0;
        rom_addr_s = pc_r;
        ram_rd_s   = 1'b0;
        ram_wr_s   = 1'b0;
        im_int_s   = 1'b0;
        din_ld_s   = 1'b0;
        acc_ld_s   = 1'b0;
        op_s       = OP_NOP;
        halted_s   = 1'b0;
        if (!rst) begin
            case (state_r)
                ST_FETCH:    rom_rd_s = bus.run;
                ST_OP_FETCH: rom_rd_s = 1'b1;
                ST_EXEC: begin
                    case (opc_s)
                        OP_LDO: begin
                            // Constant load from ROM at the operand address.
                            rom_rd_s   = 1'b1;
                            rom_addr_s = areg_r;
                            din_ld_s   = 1'b1;
                        end
                        OP_LDA, OP_ADD, OP_PRE: begin
                            ram_rd_s = 1'b1;
                            din_ld_s = 1'b1;
                        end
                        OP_STO:  ram_wr_s = 1'b1;
                        OP_ADN:  im_int_s = 1'b1;
                        default: im_int_s = 1'b0;
                    endcase
                end
                ST_WB:   acc_ld_s = writes_acc(opc_s);
                ST_HALT: halted_s = 1'b1;
                default: rom_rd_s = 1'b0;
            endcase
            // Illegal opcodes present as NOP to the ALU.
            if (op_window_s && !is_illegal(opc_s)) begin
                op_s = opc_s;
            end else begin
                op_s = OP_NOP;
            end
        end else begin
            op_s = OP_NOP;
        end
    end

    assign bus.rom_addr = rom_addr_s;
    assign bus.rom_rd   = rom_rd_s;
    assign bus.ram_addr = areg_r;
    assign bus.ram_rd   = ram_rd_s;
    assign bus.ram_wr   = ram_wr_s;
    assign bus.op       = op_s;
    assign bus.imm      = ir_r[3:0];
    assign bus.im_int   = im_int_s;
    assign bus.din_ld   = din_ld_s;
    assign bus.acc_ld   = acc_ld_s;
    assign bus.halted   = halted_s;
`ifdef SEQ_ILLEGAL_TRAP_EN
    assign bus.illegal  = illegal_r;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
// Directed, table-driven bench for cpu_sequencer: a cycle-by-cycle trace of
// a small program, a per-opcode strobe-count table, and hand-written
// sequences for reset mid-instruction, PC wrap, ADN+HLT timing and illegal
// opcodes. Honors SEQ_ILLEGAL_TRAP_EN when defined.
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run_s = 1'b0;
    logic [7:0] rom [0:255];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cpu_sequencer_if #(.AW(8)) bus ();

    cpu_sequencer #(.AW(8), .RESET_PC(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.run   = run_s;
    assign bus.instr = rom[bus.rom_addr];

    typedef struct packed {
        logic       rom_rd;
        logic [7:0] rom_addr;
        logic       ram_rd;
        logic       ram_wr;
        logic [7:0] ram_addr;
        logic [3:0] op;
        logic [3:0] imm;
        logic       im_int;
        logic       din_ld;
        logic       acc_ld;
        logic       halted;
    } obs_t;

    typedef struct {
        logic run;
        obs_t exp;
    } vec_t;

    typedef struct packed {
        logic [3:0] rom_rd;
        logic [3:0] ram_rd;
        logic [3:0] ram_wr;
        logic [3:0] din_ld;
        logic [3:0] acc_ld;
        logic [3:0] im_int;
        logic [3:0] op_cyc;
        logic [3:0] multi;
        logic       next_rd;
        logic [7:0] next_pc;
    } cnt_t;

    typedef struct {
        logic [3:0] opc;
        int         cyc;
        cnt_t       exp;
    } opv_t;

    vec_t tv[$];
    opv_t ov[$];

    function automatic obs_t sample();
        obs_t s;
        s.rom_rd   = bus.rom_rd;
        s.rom_addr = bus.rom_addr;
        s.ram_rd   = bus.ram_rd;
        s.ram_wr   = bus.ram_wr;
        s.ram_addr = bus.ram_addr;
        s.op       = bus.op;
        s.imm      = bus.imm;
        s.im_int   = bus.im_int;
        s.din_ld   = bus.din_ld;
        s.acc_ld   = bus.acc_ld;
        s.halted   = bus.halted;
        return s;
    endfunction

    function automatic obs_t o(input logic rr, input logic [7:0] ra, input logic mr,
                               input logic mw, input logic [7:0] ma, input logic [3:0] op,
                               input logic [3:0] im, input logic ii, input logic dl,
                               input logic al, input logic h);
        obs_t s;
        s = '{rr, ra, mr, mw, ma, op, im, ii, dl, al, h};
        return s;
    endfunction

    task automatic add(input logic run, input obs_t e);
        vec_t v;
        v.run = run;
        v.exp = e;
        tv.push_back(v);
    endtask

    function automatic cnt_t mkc(input int rr, input int mr, input int mw, input int dl,
                                 input int al, input int ii, input int oc,
                                 input logic [7:0] np);
        cnt_t c;
        c = '{4'(rr), 4'(mr), 4'(mw), 4'(dl), 4'(al), 4'(ii), 4'(oc), 4'd0, 1'b1, np};
        return c;
    endfunction

    task automatic addop(input logic [3:0] opc, input int cyc, input cnt_t e);
        opv_t v;
        v.opc = opc;
        v.cyc = cyc;
        v.exp = e;
        ov.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    // Leaves the bench at a negedge with rst low: the DUT sits in its first FETCH.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        obs_t s;
        cnt_t c;
        logic [3:0] hc;
        logic [3:0] ic;

        // ---------------- cycle trace of a mixed program ----------------
        add(1, o(1,8'h00,0,0,8'h00,4'h0,4'h0,0,0,0,0)); // 1 FETCH
        add(1, o(0,8'h00,0,0,8'h00,4'h0,4'h0,0,0,0,0)); // LOAD_IR
        add(1, o(0,8'h01,0,0,8'h00,4'h7,4'h2,0,0,0,0)); // DECODE ADN
        add(1, o(0,8'h01,0,0,8'h00,4'h7,4'h2,1,0,0,0)); // EXEC im_int
        add(1, o(0,8'h01,0,0,8'h00,4'h7,4'h2,0,0,1,0)); // WB acc_ld
        add(0, o(0,8'h01,0,0,8'h00,4'h0,4'h2,0,0,0,0)); // FETCH stalled
        add(1, o(1,8'h01,0,0,8'h00,4'h0,4'h2,0,0,0,0)); // FETCH
        add(1, o(0,8'h01,0,0,8'h00,4'h0,4'h2,0,0,0,0)); // LOAD_IR
        add(1, o(0,8'h02,0,0,8'h00,4'h2,4'h0,0,0,0,0)); // DECODE LDA
        add(1, o(1,8'h02,0,0,8'h00,4'h2,4'h0,0,0,0,0)); // OP_FETCH
        add(1, o(0,8'h02,0,0,8'h00,4'h2,4'h0,0,0,0,0)); // OP_LOAD
        add(1, o(0,8'h03,1,0,8'h35,4'h2,4'h0,0,1,0,0)); // EXEC ram_rd
        add(1, o(0,8'h03,0,0,8'h35,4'h2,4'h0,0,0,1,0)); // WB
        add(1, o(1,8'h03,0,0,8'h35,4'h0,4'h0,0,0,0,0)); // FETCH
        add(1, o(0,8'h03,0,0,8'h35,4'h0,4'h0,0,0,0,0)); // LOAD_IR
        add(1, o(0,8'h04,0,0,8'h35,4'h3,4'h5,0,0,0,0)); // DECODE STO
        add(1, o(1,8'h04,0,0,8'h35,4'h3,4'h5,0,0,0,0)); // OP_FETCH
        add(0, o(0,8'h04,0,0,8'h35,4'h3,4'h5,0,0,0,0)); // OP_LOAD, run low ignored
        add(0, o(0,8'h05,0,1,8'h40,4'h3,4'h5,0,0,0,0)); // EXEC ram_wr
        add(1, o(0,8'h05,0,0,8'h40,4'h3,4'h5,0,0,0,0)); // WB
        add(1, o(1,8'h05,0,0,8'h40,4'h0,4'h5,0,0,0,0)); // FETCH
        add(1, o(0,8'h05,0,0,8'h40,4'h0,4'h5,0,0,0,0)); // LOAD_IR
        add(1, o(0,8'h06,0,0,8'h40,4'h1,4'h2,0,0,0,0)); // DECODE LDO
        add(1, o(1,8'h06,0,0,8'h40,4'h1,4'h2,0,0,0,0)); // OP_FETCH
        add(1, o(0,8'h06,0,0,8'h40,4'h1,4'h2,0,0,0,0)); // OP_LOAD
        add(1, o(1,8'h80,0,0,8'h80,4'h1,4'h2,0,1,0,0)); // EXEC ROM read at areg
        add(1, o(0,8'h07,0,0,8'h80,4'h1,4'h2,0,0,1,0)); // WB
        add(1, o(1,8'h07,0,0,8'h80,4'h0,4'h2,0,0,0,0)); // FETCH
        add(1, o(0,8'h07,0,0,8'h80,4'h0,4'h2,0,0,0,0)); // LOAD_IR
        add(1, o(0,8'h08,0,0,8'h80,4'hA,4'h0,0,0,0,0)); // DECODE JMP
        add(1, o(1,8'h08,0,0,8'h80,4'hA,4'h0,0,0,0,0)); // OP_FETCH
        add(1, o(0,8'h08,0,0,8'h80,4'hA,4'h0,0,0,0,0)); // OP_LOAD
        add(1, o(0,8'h09,0,0,8'h10,4'hA,4'h0,0,0,0,0)); // EXEC
        add(1, o(0,8'h09,0,0,8'h10,4'hA,4'h0,0,0,0,0)); // WB pc<=areg
        add(1, o(1,8'h10,0,0,8'h10,4'h0,4'h0,0,0,0,0)); // FETCH at target
        add(1, o(0,8'h10,0,0,8'h10,4'h0,4'h0,0,0,0,0)); // LOAD_IR
        add(1, o(0,8'h11,0,0,8'h10,4'h8,4'h0,0,0,0,0)); // DECODE INC
        add(1, o(0,8'h11,0,0,8'h10,4'h8,4'h0,0,0,0,0)); // EXEC
        add(1, o(0,8'h11,0,0,8'h10,4'h8,4'h0,0,0,1,0)); // WB
        add(1, o(1,8'h11,0,0,8'h10,4'h0,4'h0,0,0,0,0)); // FETCH
        add(1, o(0,8'h11,0,0,8'h10,4'h0,4'h0,0,0,0,0)); // LOAD_IR
        add(1, o(0,8'h12,0,0,8'h10,4'hF,4'h0,0,0,0,0)); // DECODE HLT
        add(1, o(0,8'h12,0,0,8'h10,4'hF,4'h0,0,0,0,0)); // EXEC
        add(1, o(0,8'h12,0,0,8'h10,4'h0,4'h0,0,0,0,1)); // HALT
        add(1, o(0,8'h12,0,0,8'h10,4'h0,4'h0,0,0,0,1)); // HALT holds
        add(0, o(0,8'h12,0,0,8'h10,4'h0,4'h0,0,0,0,1)); // HALT holds

        // ---------------- per-opcode strobe counts (imm 3, operand 0x5A) ----
        //           rom ram_rd ram_wr din acc im op_cyc next_pc
        addop(4'h0, 5, mkc(1, 0, 0, 0, 0, 0, 5, 8'h01));
        addop(4'h1, 7, mkc(3, 0, 0, 1, 1, 0, 5, 8'h02));
        addop(4'h2, 7, mkc(2, 1, 0, 1, 1, 0, 5, 8'h02));
        addop(4'h3, 7, mkc(2, 0, 1, 0, 0, 0, 5, 8'h02));
        addop(4'h4, 7, mkc(2, 1, 0, 1, 0, 0, 5, 8'h02));
        addop(4'h5, 7, mkc(2, 1, 0, 1, 1, 0, 5, 8'h02));
        addop(4'h6, 5, mkc(1, 0, 0, 0, 0, 0, 3, 8'h01));
        addop(4'h7, 5, mkc(1, 0, 0, 0, 1, 1, 3, 8'h01));
        addop(4'h8, 5, mkc(1, 0, 0, 0, 1, 0, 3, 8'h01));
        addop(4'h9, 5, mkc(1, 0, 0, 0, 1, 0, 3, 8'h01));
        addop(4'hA, 7, mkc(2, 0, 0, 0, 0, 0, 5, 8'h5A));

        // ---------------- apply the trace ----------------
        clear_rom();
        rom[8'h00] = 8'h72; rom[8'h01] = 8'h20; rom[8'h02] = 8'h35;
        rom[8'h03] = 8'h35; rom[8'h04] = 8'h40; rom[8'h05] = 8'h12;
        rom[8'h06] = 8'h80; rom[8'h07] = 8'hA0; rom[8'h08] = 8'h10;
        rom[8'h10] = 8'h80; rom[8'h11] = 8'hF0; rom[8'h80] = 8'h5C;
        do_reset();
        for (int i = 0; i < tv.size(); i++) begin
            run_s = tv[i].run;
            #1;
            chk($sformatf("trace[%0d]", i), 64'(sample()), 64'(tv[i].exp));
            step();
        end

        // ---------------- apply the opcode table ----------------
        for (int k = 0; k < ov.size(); k++) begin
            clear_rom();
            rom[8'h00] = {ov[k].opc, 4'h3};
            rom[8'h01] = 8'h5A;
            run_s = 1'b0;
            do_reset();
            run_s = 1'b1;
            c = '0;
            for (int n = 0; n < ov[k].cyc; n++) begin
                #1;
                s = sample();
                c.rom_rd = c.rom_rd + {3'b000, s.rom_rd};
                c.ram_rd = c.ram_rd + {3'b000, s.ram_rd};
                c.ram_wr = c.ram_wr + {3'b000, s.ram_wr};
                c.din_ld = c.din_ld + {3'b000, s.din_ld};
                c.acc_ld = c.acc_ld + {3'b000, s.acc_ld};
                c.im_int = c.im_int + {3'b000, s.im_int};
                c.op_cyc = c.op_cyc + {3'b000, (s.op == ov[k].opc)};
                c.multi  = c.multi + {3'b000, ((2'(s.rom_rd) + 2'(s.ram_rd) + 2'(s.ram_wr)) > 2'd1)};
                step();
            end
            #1;
            s = sample();
            c.next_rd = s.rom_rd;
            c.next_pc = s.rom_addr;
            chk($sformatf("opcode_%0h", ov[k].opc), 64'(c), 64'(ov[k].exp));
        end

        // ---------------- reset in the middle of STO's EXEC ----------------
        clear_rom();
        rom[8'h00] = 8'h35;
        rom[8'h01] = 8'h40;
        run_s = 1'b0;
        do_reset();
        run_s = 1'b1;
        repeat (5) step();
        #1;
        chk("sto_exec", 64'(sample()), 64'(o(0,8'h02,0,1,8'h40,4'h3,4'h5,0,0,0,0)));
        #1;
        rst = 1'b1;
        #1;
        chk("in_reset", 64'(sample()), 64'(o(0,8'h00,0,0,8'h00,4'h0,4'h0,0,0,0,0)));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_reset_fetch", 64'(sample()), 64'(o(1,8'h00,0,0,8'h00,4'h0,4'h0,0,0,0,0)));
        @(negedge clk);

        // ---------------- ADN then HLT: halted at cycle 10 ----------------
        clear_rom();
        rom[8'h00] = 8'h72;
        rom[8'h01] = 8'hF0;
        run_s = 1'b0;
        do_reset();
        run_s = 1'b1;
        hc = 4'd0;
        ic = 4'd0;
        for (int n = 1; n <= 9; n++) begin
            #1;
            hc = hc + {3'b000, bus.halted};
            ic = ic + {3'b000, bus.im_int};
            step();
        end
        chk("adn_hlt_counts", 64'({hc, ic}), 64'({4'd0, 4'd1}));
        chk("halt_cycle10", 64'(bus.halted), 64'd1);
        repeat (3) step();
        chk("halt_sticky", 64'(bus.halted), 64'd1);

        // ---------------- PC wrap: STO at 0xFF, operand at 0x00 ----------------
        clear_rom();
        rom[8'h00] = 8'hA0;
        rom[8'h01] = 8'hFF;
        rom[8'hFF] = 8'h30;
        run_s = 1'b0;
        do_reset();
        run_s = 1'b1;
        repeat (7) step();
        chk("wrap_fetch_ff", 64'({bus.rom_rd, bus.rom_addr}), 64'({1'b1, 8'hFF}));
        repeat (3) step();
        chk("wrap_opfetch_00", 64'({bus.rom_rd, bus.rom_addr}), 64'({1'b1, 8'h00}));
        repeat (2) step();
        chk("wrap_exec", 64'({bus.ram_wr, bus.ram_addr}), 64'({1'b1, 8'hA0}));
        repeat (2) step();
        chk("wrap_next_fetch", 64'({bus.rom_rd, bus.rom_addr}), 64'({1'b1, 8'h01}));

        // ---------------- illegal opcode 0xB0 ----------------
        clear_rom();
        rom[8'h00] = 8'hB0;
        rom[8'h01] = 8'hF0;
        run_s = 1'b0;
        do_reset();
        run_s = 1'b1;
`ifdef SEQ_ILLEGAL_TRAP_EN
        repeat (2) step();
        chk("ill_decode_op", 64'(bus.op), 64'd0);
        step();
        chk("ill_trap", 64'({bus.halted, bus.illegal, bus.rom_rd}), 64'({1'b1, 1'b1, 1'b0}));
        repeat (3) step();
        chk("ill_trap_hold", 64'({bus.halted, bus.illegal}), 64'({1'b1, 1'b1}));
`else
        #1;
        chk("ill_c1", 64'(sample()), 64'(o(1,8'h00,0,0,8'h00,4'h0,4'h0,0,0,0,0)));
        step();
        chk("ill_c2", 64'(sample()), 64'(o(0,8'h00,0,0,8'h00,4'h0,4'h0,0,0,0,0)));
        step();
        chk("ill_c3", 64'(sample()), 64'(o(0,8'h01,0,0,8'h00,4'h0,4'h0,0,0,0,0)));
        step();
        chk("ill_c4", 64'(sample()), 64'(o(0,8'h01,0,0,8'h00,4'h0,4'h0,0,0,0,0)));
        step();
        chk("ill_c5", 64'(sample()), 64'(o(0,8'h01,0,0,8'h00,4'h0,4'h0,0,0,0,0)));
        step();
        #1;
        chk("ill_next_fetch", 64'(sample()), 64'(o(1,8'h01,0,0,8'h00,4'h0,4'h0,0,0,0,0)));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle instruction sequencer and decoder for the 8-bit CPU.
- Fetches instruction bytes from ROM, decodes the 4-bit opcode, and drives the ALU opcode, the immediate strobe and the memory/accumulator control strobes.
- Sits upstream of the ALU: it issues the op/im_int stream the ALU consumes.
- Owns the program counter, instruction register and operand-address register.

Parameters:
- AW, 8, ROM/RAM address width and PC width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  permits a new instruction fetch when high.
- instr  in  8  ROM read data: opcode [7:4], immediate [3:0].
- rom_addr  out  AW  ROM address.
- rom_rd  out  1  ROM read strobe.
- ram_addr  out  AW  RAM address, equal to the operand register.
- ram_rd  out  1  RAM read strobe.
- ram_wr  out  1  RAM write strobe; the accumulator drives the data bus.
- op  out  4  ALU opcode.
- imm  out  4  immediate nibble, feeds alu_in[3:0].
- im_int  out  1  one-cycle immediate-add latch pulse to the ALU.
- din_ld  out  1  loads the memory data bus into the ALU input register.
- acc_ld  out  1  loads alu_out into the accumulator.
- halted  out  1  high while in the HALT state.

Behaviour:
- Opcodes: NOP 0, LDO 1, LDA 2, STO 3, PRE 4, ADD 5, LDM 6, ADN 7, INC 8, DEC 9, JMP A, HLT F. Codes B–E are illegal.
- Two-byte instructions (second byte is the address): LDO, LDA, STO, PRE, ADD, JMP. All others are one byte.
- States: FETCH, LOAD_IR, DECODE, OP_FETCH, OP_LOAD, EXEC, WB, HALT.
- FETCH:
  - rom_rd=1, rom_addr=pc.
  - Goes to LOAD_IR when run=1; otherwise holds with rom_rd=0.
- LOAD_IR: ir<=instr; pc<=pc+1.
- DECODE:
  - Two-byte instruction → OP_FETCH. One-byte instruction → EXEC.
  - op=ir[7:4], held from DECODE through WB. Outside DECODE..WB, op=NOP.
- OP_FETCH: rom_rd=1, rom_addr=pc.
- OP_LOAD: areg<=instr; pc<=pc+1. Next state EXEC.
- EXEC strobes, one cycle each:
  - LDO: rom_rd=1, rom_addr=areg, din_ld=1.
  - LDA, ADD, PRE: ram_rd=1, din_ld=1.
  - STO: ram_wr=1.
  - ADN: im_int=1, imm=ir[3:0].
  - HLT: next state HALT.
  - All other opcodes: no strobes.
- WB:
  - acc_ld=1 for LDO, LDA, ADD, ADN, INC, DEC.
  - JMP: pc<=areg.
  - Next state FETCH.
- HALT: halted=1, all strobes 0. Only rst exits.
- Cycle counts:
  - One-byte instruction: 5 cycles (FETCH..WB).
  - Two-byte instruction: 7 cycles.
  - FETCH stalls while run=0.
- Strobes are registered-state decodes and glitch-free: at most one of rom_rd, ram_rd, ram_wr is high per cycle.
- imm=ir[3:0] continuously. im_int is high in exactly one cycle per ADN and never otherwise.
- ram_addr=areg at all times.
- PC wrap: pc=2^AW−1 increments to 0. An operand byte at the top address is read from there and pc wraps to 0.
- Reset, at any time including mid-instruction:
  - pc=RESET_PC; ir=0; areg=0; state=FETCH.
  - All strobes 0, op=0, imm=0, halted=0.
- run is sampled only in FETCH. Deasserting run mid-instruction does not stall the instruction in progress.
- Illegal opcodes run as a one-byte NOP (op output 0, no strobes); see the optional feature.

Optional Feature:
- Macro: SEQ_ILLEGAL_TRAP_EN.
- Defined:
  - Opcodes B–E go DECODE→HALT.
  - halted=1, and an extra output port illegal (1 bit) is set and held high until rst.
- Undefined:
  - No illegal port.
  - Opcodes B–E execute as a 5-cycle NOP.

Test Plan:
- Reset mid-EXEC of STO (ram_wr=1), release → all outputs 0 during reset; first FETCH has rom_addr=RESET_PC.
- ROM {0x72, 0xF0}, run=1 → im_int pulses once with imm=2; acc_ld in the next cycle; then halted=1 at cycle 10 and stays high.
- ROM {0x20, 0x35, 0xF0} → EXEC of LDA: ram_rd=1, ram_addr=0x35, din_ld=1; WB: acc_ld=1; 7 cycles total.
- ROM {0xA0, 0x10} then 0x10: {0x80, 0xF0} → after JMP, rom_addr=0x10; INC gives acc_ld; halted follows.
- PC at 0xFF holding 0x30 with operand at 0x00 → ram_addr=areg=ROM[0x00]; pc resumes at 0x01.
- Opcode 0xB0 → with SEQ_ILLEGAL_TRAP_EN: halted=1, illegal=1. Without it: NOP in 5 cycles, then next fetch at pc+1.
